// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants used by the integer datapath.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/configurable_demux.sv
// Routes data_i to the output lane selected by sel_i; all other lanes are zero.
module configurable_demux #(
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned DATA_W = 1
) (
    input  logic [DATA_W-1:0]                   data_i,
    input  logic [SEL_W-1:0]                    sel_i,
    output logic [2**SEL_W-1:0][DATA_W-1:0]     data_o
);

    always_comb begin
        data_o        = '0;
        data_o[sel_i] = data_i;
    end

endmodule

// File: rtl/register_bank.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, optional write-to-read bypass, write counter.
module register_bank
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = REG_ADDR_W,
    parameter int unsigned DATA_W    = XLEN,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [15:0]       wr_cnt_o
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  dec_we;
    logic [NREGS-1:0]  reg_we;
    logic              wr_fire;

    configurable_demux #(
        .SEL_W  (ADDR_W),
        .DATA_W (1)
    ) u_we_demux (
        .data_i (we_i),
        .sel_i  (waddr_i),
        .data_o (dec_we)
    );

    // Lane 0 is forced low so x0 can never be written or counted.
    always_comb begin
        reg_we    = dec_we;
        reg_we[0] = 1'b0;
        wr_fire   = resetb_i & (|reg_we);
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (reg_we[i]) begin
                    regs[i] <= wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_cnt_o <= '0;
        end else if (wr_fire && (wr_cnt_o != '1)) begin
            wr_cnt_o <= wr_cnt_o + 16'd1;
        end
    end

    // wr_fire includes resetb_i, so the bypass stays silent while reset is held.
    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = regs[raddr1_i];
            if (BYPASS_EN && wr_fire && (raddr1_i == waddr_i)) begin
                rdata1_o = wdata_i;
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != '0) begin
            rdata2_o = regs[raddr2_i];
            if (BYPASS_EN && wr_fire && (raddr2_i == waddr_i)) begin
                rdata2_o = wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: one bypassing and one non-bypassing register_bank
// share stimulus; a flat-array model predicts both.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        resetb;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [15:0] cnt_b, cnt_n;

    int tests = 0;
    int fails = 0;

    logic [31:0] m [32];
    int unsigned mcnt;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] exp1_b;
        logic [31:0] exp2_b;
        logic [31:0] exp1_n;
        logic [31:0] exp2_n;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    register_bank #(.ADDR_W(5), .DATA_W(32), .BYPASS_EN(1'b1)) dut_b (
        .clk_i(clk), .resetb_i(resetb), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr1_i(raddr1), .raddr2_i(raddr2), .rdata1_o(rd1_b), .rdata2_o(rd2_b),
        .wr_cnt_o(cnt_b)
    );

    register_bank #(.ADDR_W(5), .DATA_W(32), .BYPASS_EN(1'b0)) dut_n (
        .clk_i(clk), .resetb_i(resetb), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr1_i(raddr1), .raddr2_i(raddr2), .rdata1_o(rd1_n), .rdata2_o(rd2_n),
        .wr_cnt_o(cnt_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit bypass);
        if (a == 0) return 32'h0;
        if (bypass && resetb && we && waddr != 0 && a == waddr) return wdata;
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        mcnt = 0;
    endtask

    task automatic model_commit();
        if (resetb && we && waddr != 0) begin
            m[waddr] = wdata;
            if (mcnt < 65535) mcnt++;
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, " rd1 bypass"},    rd1_b, model_read(raddr1, 1'b1));
        check({tag, " rd2 bypass"},    rd2_b, model_read(raddr2, 1'b1));
        check({tag, " rd1 no-bypass"}, rd1_n, model_read(raddr1, 1'b0));
        check({tag, " rd2 no-bypass"}, rd2_n, model_read(raddr2, 1'b0));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, " cnt bypass"},    {16'h0, cnt_b}, mcnt);
        check({tag, " cnt no-bypass"}, {16'h0, cnt_n}, mcnt);
    endtask

    // Inputs change just after the falling edge; the commit happens at the next rising edge.
    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h12345678, 5'd5, 5'd31, 32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'hFEDCBA98, 5'd5, 5'd31, 32'h12345678, 32'hFEDCBA98, 32'h12345678, 32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 32'h12345678, 32'hFEDCBA98, 32'h12345678, 32'hFEDCBA98};
        vecs[3] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h00000001, 5'd0, 5'd7,  32'h0,        32'h1,        32'h0,        32'h0};
        vecs[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'h1};

        resetb = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        model_reset();

        // Reset asserted mid-cycle, then every address read on both ports.
        #3 resetb = 1'b0;
        raddr1 = 5'd9; raddr2 = 5'd31;
        #1 check("in-reset rd1", rd1_b, 32'h0);
        check("in-reset rd2", rd2_n, 32'h0);
        @(negedge clk);
        resetb = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = a[4:0];
            raddr2 = 5'(31 - a);
            #1 check_reads("post-reset");
        end
        check_cnt("post-reset");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr1 = vecs[i].raddr1; raddr2 = vecs[i].raddr2;
            #2;
            check($sformatf("vec%0d rd1 bypass", i),    rd1_b, vecs[i].exp1_b);
            check($sformatf("vec%0d rd2 bypass", i),    rd2_b, vecs[i].exp2_b);
            check($sformatf("vec%0d rd1 no-bypass", i), rd1_n, vecs[i].exp1_n);
            check($sformatf("vec%0d rd2 no-bypass", i), rd2_n, vecs[i].exp2_n);
            tick();
        end
        we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd0;
        #2;
        check("x7 after bypass write b", rd1_b, 32'hA5A5A5A5);
        check("x7 after bypass write n", rd1_n, 32'hA5A5A5A5);
        check("x0 after DEADBEEF",       rd2_b, 32'h0);
        check("table cnt b", {16'h0, cnt_b}, 32'd4);
        check("table cnt n", {16'h0, cnt_n}, 32'd4);

        // Randomized traffic against the array model.
        for (int i = 0; i < 400; i++) begin
            we     = ($urandom_range(0, 3) != 0);
            waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            #2 check_reads($sformatf("rand%0d", i));
            tick();
        end
        we = 1'b0;
        #2 check_cnt("rand");

        // Async reset between edges while a write is pending.
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; raddr1 = 5'd3; raddr2 = 5'd3;
        tick();
        wdata = 32'h11111111;
        #1 check("x3 loaded n", rd1_n, 32'hCAFEF00D);
        #1 resetb = 1'b0;
        model_reset();
        #1 check("x3 async clear b", rd1_b, 32'h0);
        check("x3 async clear n", rd2_n, 32'h0);
        check_cnt("async reset");
        tick();
        check("x3 held in reset b", rd1_b, 32'h0);
        check("x3 held in reset n", rd1_n, 32'h0);
        check_cnt("held reset");
        resetb = 1'b1;
        #2 check_reads("reset release");
        tick();
        #1 check_reads("first write after reset");
        check("x3 first write n", rd1_n, 32'h11111111);
        check_cnt("first write after reset");

        // Counter saturation with repeated writes to x1.
        we = 1'b1; waddr = 5'd1; raddr1 = 5'd1; raddr2 = 5'd31;
        for (int i = 0; i < 65540; i++) begin
            wdata = i;
            tick();
        end
        we = 1'b0;
        #2;
        check("sat cnt b", {16'h0, cnt_b}, 32'h0000FFFF);
        check("sat cnt n", {16'h0, cnt_n}, 32'h0000FFFF);
        check("sat x1 b",  rd1_b, 32'd65539);
        check("sat x1 n",  rd1_n, 32'd65539);
        check_cnt("sat model");
        check_reads("sat reads");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 2^ADDR_W x DATA_W integer register file for the RISC-V monocycle core.
- Sits directly downstream of the write-back select path: it consumes the selected write-back word plus destination index, and supplies both source operands to the ALU stage.
- Two asynchronous read ports and one synchronous write port.
- Register x0 is hardwired to zero; optional write-to-read bypass.

Parameters:
- ADDR_W, 5, register index width; register count is 2^ADDR_W.
- DATA_W, 32, register width in bits.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = it returns the stored value.

Ports:
- clk_i  input  1  system clock, rising-edge active.
- resetb_i  input  1  asynchronous, active-low reset.
- we_i  input  1  write enable, sampled on rising clk_i.
- waddr_i  input  ADDR_W  destination register index.
- wdata_i  input  DATA_W  write-back data.
- raddr1_i  input  ADDR_W  source register 1 index.
- raddr2_i  input  ADDR_W  source register 2 index.
- rdata1_o  output  DATA_W  source register 1 value, combinational.
- rdata2_o  output  DATA_W  source register 2 value, combinational.
- wr_cnt_o  output  16  count of committed writes, saturating; debug/perf use.

Behaviour:
- Clock and reset: single clock domain clk_i. Reset is asynchronous and active-low on resetb_i; all storage clears immediately on assertion, independent of clk_i.
- Reset values: every register = 0, wr_cnt_o = 0. While reset is held, rdata1_o/rdata2_o = 0 for any address.
- Write:
  - On rising clk_i with resetb_i high, we_i=1 and waddr_i!=0: reg[waddr_i] <= wdata_i. The value is visible on a read port from the following cycle (latency 1).
  - Writes with waddr_i=0 are discarded and reg[0] stays 0.
- Write-enable decode: the 1-bit we_i is demultiplexed by waddr_i into 2^ADDR_W one-hot per-register enables. Bit 0 of the decoded vector is forced low.
- Read:
  - Purely combinational. rdataN_o = reg[raddrN_i], except that raddrN_i=0 always returns 0.
  - Both ports are independent; raddr1_i == raddr2_i is legal and both ports return the same value.
- Bypass, BYPASS_EN=1:
  - If we_i=1, waddr_i!=0 and raddrN_i==waddr_i, then rdataN_o = wdata_i in the same cycle. This creates a combinational path wdata_i -> rdataN_o.
  - With BYPASS_EN=0 the same case returns the old stored value.
- wr_cnt_o:
  - Increments by 1 on each committed write (we_i=1, waddr_i!=0).
  - Saturates at 16'hFFFF.
  - Writes to x0 do not count.
- Boundary conditions:
  - Reset asserted mid-cycle while we_i=1: no write commits and all registers read 0.
  - Reset deasserted: the first write takes effect on the first rising edge after resetb_i goes high.
  - Address 2^ADDR_W-1 is writable and readable like any other register; no wrap-around exists because the index is fully decoded.
  - X/Z on we_i is not required to be handled; the bench must drive known values.

Decomposition:
- Shared package riscv_pkg holds:
  - constants REG_ADDR_W=5 and XLEN=32;
  - typedef reg_addr_t = logic [REG_ADDR_W-1:0];
  - typedef xlen_t = logic [XLEN-1:0];
  - constant REG_ZERO = '0.
- One sub-module: the write-enable decode reuses the existing configurable_demux, instantiated as configurable_demux #(ADDR_W,1) with data_i=we_i and sel_i=waddr_i.
- Storage, read muxes, bypass and counter stay in register_bank.

Test Plan:
- Reset then read: assert resetb_i=0 mid-cycle, release, read all 32 addresses on both ports -> every rdata = 32'h0 and wr_cnt_o = 0.
- Basic write/read: write x5=32'h12345678 and x31=32'hFEDCBA98 on consecutive edges, then raddr1=5, raddr2=31 -> rdata1=32'h12345678, rdata2=32'hFEDCBA98, wr_cnt_o=2.
- x0 protection: we_i=1, waddr_i=0, wdata_i=32'hDEADBEEF, then read x0 on both ports -> 32'h0 and wr_cnt_o unchanged.
- Bypass: x7 holds 32'h1, same cycle we_i=1, waddr_i=7, wdata_i=32'hA5A5A5A5, raddr1=7 -> rdata1=32'hA5A5A5A5 with BYPASS_EN=1 and 32'h1 with BYPASS_EN=0; both read 32'hA5A5A5A5 next cycle.
- Async reset mid-operation: load x3=32'hCAFEF00D, drop resetb_i between edges with we_i=1 -> rdata for x3 reads 32'h0 immediately, before the next clock edge; no write commits while reset is held.
- Counter saturation: force 65540 writes to x1 -> wr_cnt_o stops at 16'hFFFF and x1 holds the last written value.
